// File: rtl/onehot_mask_encoder.sv
// Turns a DATA_W-bit mask into one CODE_W-bit index per set bit, one per cycle, over valid/ready.
// Scan order is ascending by default; define ONEHOT_MASK_ENCODER_MSB_FIRST_EN for descending.
module onehot_mask_encoder #(
  parameter int DATA_W = 32,
  parameter int CODE_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_mask,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CODE_W-1:0] out_code,
  output logic              out_last,
  output logic              empty_drop
);

  typedef enum logic {S_IDLE, S_EMIT} state_t;

  state_t              r_state, w_state_nxt;
  logic [DATA_W-1:0]   r_mask, w_mask_nxt;
  logic [CODE_W-1:0]   r_code, w_code_nxt;
  logic                r_last, w_last_nxt;
  logic                r_drop, w_drop_nxt;

  logic                w_fire_out;
  logic                w_accept;
  logic [DATA_W-1:0]   w_rem;

  function automatic logic [CODE_W-1:0] scan_first(input logic [DATA_W-1:0] v);
    logic [CODE_W-1:0] idx;
    scan_first = '0;
`ifdef ONEHOT_MASK_ENCODER_MSB_FIRST_EN
    for (int unsigned i = 0; i < DATA_W; i++) begin
      idx = CODE_W'(i);
      if (v[idx]) scan_first = idx;
    end
`else
    for (int unsigned i = DATA_W; i > 0; i--) begin
      idx = CODE_W'(i - 1);
      if (v[idx]) scan_first = idx;
    end
`endif
  endfunction

  // For a non-zero vector, clearing the lowest set bit leaves zero only when exactly one bit was set.
  function automatic logic is_single(input logic [DATA_W-1:0] v);
    is_single = ((v & (v - DATA_W'(1))) == '0);
  endfunction

  assign out_valid  = (r_state == S_EMIT);
  assign out_code   = r_code;
  assign out_last   = r_last;
  assign empty_drop = r_drop;

  assign w_fire_out = out_valid && out_ready;
  assign in_ready   = (r_state == S_IDLE) || (w_fire_out && r_last);
  assign w_accept   = in_valid && in_ready;
  assign w_rem      = r_mask & ~(DATA_W'(1) << r_code);

  always_comb begin
    w_state_nxt = r_state;
    w_mask_nxt  = r_mask;
    w_code_nxt  = r_code;
    w_last_nxt  = r_last;
    w_drop_nxt  = 1'b0;
    // A new accept takes priority so the final handshake can reload without a bubble.
    if (w_accept) begin
      if (in_mask != '0) begin
        w_state_nxt = S_EMIT;
        w_mask_nxt  = in_mask;
        w_code_nxt  = scan_first(in_mask);
        w_last_nxt  = is_single(in_mask);
      end else begin
        w_state_nxt = S_IDLE;
        w_mask_nxt  = '0;
        w_code_nxt  = '0;
        w_last_nxt  = 1'b0;
        w_drop_nxt  = 1'b1;
      end
    end else if (w_fire_out) begin
      if (r_last) begin
        w_state_nxt = S_IDLE;
        w_mask_nxt  = '0;
        w_code_nxt  = '0;
        w_last_nxt  = 1'b0;
      end else begin
        w_mask_nxt  = w_rem;
        w_code_nxt  = scan_first(w_rem);
        w_last_nxt  = is_single(w_rem);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_mask  <= '0;
      r_code  <= '0;
      r_last  <= 1'b0;
      r_drop  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_mask  <= w_mask_nxt;
      r_code  <= w_code_nxt;
      r_last  <= w_last_nxt;
      r_drop  <= w_drop_nxt;
    end
  end

endmodule

// File: doc/onehot_mask_encoder.md
Name: onehot_mask_encoder

Overview:
- Reverse of the 5-to-32 one-hot decoder: turns a 32-bit mask into a stream of 5-bit indices, one per set bit, emitted one code per cycle.
- Sits between activation/weight sparsity masks and the address generators, which consume the indices of non-zero lanes.
- Valid/ready handshake on both sides; the mask is buffered internally and drained one bit at a time.

Parameters:
- DATA_W, 32, mask width; must equal 2**CODE_W.
- CODE_W, 5, output index width.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  mask offered.
- in_ready  out  1  block can take a mask this cycle.
- in_mask  in  DATA_W  mask to encode.
- out_valid  out  1  out_code is valid.
- out_ready  in  1  downstream accepts out_code.
- out_code  out  CODE_W  index of the current set bit.
- out_last  out  1  current code is the final set bit of this mask.
- empty_drop  out  1  one-cycle pulse: an all-zero mask was accepted and dropped.

Behaviour:
- Reset (async, rst=1): state IDLE, internal mask register=0, out_valid=0, out_code=0, out_last=0, empty_drop=0. A reset mid-drain discards the remaining bits; no further outputs are emitted.
- States:
  - IDLE: no mask held.
  - EMIT: mask held and out_valid=1.
- in_ready = (state==IDLE) OR (out_valid AND out_ready AND out_last). This is a combinational path from out_ready and is allowed.
- Accept (in_valid AND in_ready) with a non-zero mask:
  - On the next edge, latch the mask and go to EMIT.
  - out_code = lowest set bit index; out_last = (popcount==1); out_valid=1.
  - Latency from accept to first out_valid: 1 cycle.
- Accept with in_mask==0:
  - Go to or stay in IDLE with no output.
  - empty_drop=1 for exactly the next cycle.
- In EMIT, on handshake (out_valid AND out_ready):
  - Clear the bit at out_code in the mask register.
  - If out_last=1: go to IDLE, or reload if a new mask is accepted in the same cycle (back-to-back, no bubble).
  - Otherwise: out_code = next set bit in scan order; out_last recomputed on the remaining bits.
  - Throughput: 1 code/cycle.
- Stall (out_valid=1, out_ready=0): out_code and out_last hold stable, the mask register holds, in_ready=0.
- out_code, out_last and out_valid are registered. The next-index select is a combinational priority encoder on the mask register with the current bit masked off.
- Boundaries:
  - Single-bit mask: one output with out_last=1.
  - Mask 0xFFFFFFFF: 32 outputs, codes 0..31, out_last only on code 31.
  - Bit 31 alone: code 31.
  - in_valid while busy and not on the last handshake: ignored, and the source must hold it.

Optional Feature:
- Macro: ONEHOT_MASK_ENCODER_MSB_FIRST_EN.
- Defined: scan order is highest set bit first. Codes are emitted in descending order; out_last is on the lowest set bit.
- Undefined (default): scan order is lowest set bit first, ascending.
- Ports, handshake and latency are identical in both builds.

Test Plan:
- Reset then in_mask=0x0000_0001, out_ready=1 -> one cycle later out_valid=1, out_code=0, out_last=1; next cycle out_valid=0, in_ready=1.
- in_mask=0x8000_0011, out_ready=1 -> codes 0,4,31 on consecutive cycles, out_last only with 31; with the MSB_FIRST macro defined -> 31,4,0.
- in_mask=0xFFFF_FFFF, out_ready toggled 1/0 every cycle -> 32 codes 0..31 in order, each held stable during stalls, none lost or duplicated.
- Back-to-back: 0x0000_0006 then 0x0000_0100 offered with in_valid held -> codes 1,2,8 on three consecutive cycles with no bubble.
- in_mask=0x0 accepted -> empty_drop=1 for one cycle, out_valid stays 0, in_ready stays 1.
- rst asserted mid-drain of 0x0000_00F0 after code 4 -> out_valid=0 immediately (async); after release, in_ready=1 and no remaining codes (5,6,7) appear.
